lru_cam: RTL

//  Parametrised content-addressable memory with registered lookup and automatic

---
 rtl/cam_pkg.sv | 28 ++
 rtl/lru_age_tracker.sv | 69 ++++++
 rtl/lru_cam.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared types and one-hot encoder for the LRU CAM.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    localparam int c_max_entries = 256;
    localparam int c_idx_w       = 8;

    typedef logic [c_idx_w-1:0] cam_idx_t;
    typedef logic [c_idx_w-1:0] cam_age_t;

    localparam cam_age_t CAM_AGE_MRU = '0;

    // Callers guarantee at most one bit set, so OR-ing indices is exact.
    function automatic cam_idx_t oh_to_idx(input logic [c_max_entries-1:0] oh);
        cam_idx_t idx;
        idx = '0;
        for (int i = 0; i < c_max_entries; i++) begin
            if (oh[i]) idx = idx | cam_idx_t'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lru_age_tracker.sv
`default_nettype none
// ============================================================================
// Module      : lru_age_tracker
// Description : Per-slot LRU ages with two ordered touches and victim output.
// Revision    : 1.0 - initial release
// ============================================================================
module lru_age_tracker
    import cam_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_en,
    input  logic                   touch_a_en,
    input  logic [INDEX_WIDTH-1:0] touch_a_idx,
    input  logic                   touch_b_en,
    input  logic [INDEX_WIDTH-1:0] touch_b_idx,
    output logic [INDEX_WIDTH-1:0] victim_idx
);

    localparam logic [INDEX_WIDTH-1:0] c_age_lru = INDEX_WIDTH'(NUM_ENTRIES - 1);

    logic [INDEX_WIDTH-1:0] r_age   [NUM_ENTRIES];
    logic [INDEX_WIDTH-1:0] w_age_a [NUM_ENTRIES];
    logic [INDEX_WIDTH-1:0] w_age_b [NUM_ENTRIES];
    logic [INDEX_WIDTH-1:0] w_ref_a;
    logic [INDEX_WIDTH-1:0] w_ref_b;
    logic [NUM_ENTRIES-1:0] w_oldest_oh;

    // Lookup touch first, then the update touch on top of its result.
    always_comb begin
        w_age_a = r_age;
        w_ref_a = r_age[touch_a_idx];
        if (touch_a_en) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (r_age[i] < w_ref_a) w_age_a[i] = r_age[i] + INDEX_WIDTH'(1);
            end
            w_age_a[touch_a_idx] = CAM_AGE_MRU[INDEX_WIDTH-1:0];
        end
        w_age_b = w_age_a;
        w_ref_b = w_age_a[touch_b_idx];
        if (touch_b_en) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_age_a[i] < w_ref_b) w_age_b[i] = w_age_a[i] + INDEX_WIDTH'(1);
            end
            w_age_b[touch_b_idx] = CAM_AGE_MRU[INDEX_WIDTH-1:0];
        end
    end

    always_comb begin
        w_oldest_oh = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_oldest_oh[i] = (r_age[i] == c_age_lru);
        end
        victim_idx = INDEX_WIDTH'(oh_to_idx(c_max_entries'(w_oldest_oh)));
    end

    always_ff @(posedge clk) begin
        if (reset || flush_en) begin
            for (int i = 0; i < NUM_ENTRIES; i++) r_age[i] <= INDEX_WIDTH'(i);
        end else begin
            r_age <= w_age_b;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lru_cam.sv
`default_nettype none
// ============================================================================
// Module      : lru_cam
// Description : CAM with registered lookup, auto slot allocation and LRU evict.
//               Define LRU_CAM_BYPASS_EN to let a lookup see a same-cycle update.
// Revision    : 1.0 - initial release
// ============================================================================
module lru_cam
    import cam_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int KEY_WIDTH   = 32,
    parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lookup_en,
    input  logic [KEY_WIDTH-1:0]   lookup_key,
    output logic                   lookup_hit,
    output logic [INDEX_WIDTH-1:0] lookup_idx,
    input  logic                   update_en,
    input  logic                   update_valid,
    input  logic [KEY_WIDTH-1:0]   update_key,
    output logic [INDEX_WIDTH-1:0] update_idx,
    output logic                   update_found,
    output logic                   update_evict,
    output logic [KEY_WIDTH-1:0]   update_evict_key,
    input  logic                   flush_en
);

    logic [NUM_ENTRIES-1:0] r_valid;
    logic [KEY_WIDTH-1:0]   r_key [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] w_lk_match;
    logic [NUM_ENTRIES-1:0] w_up_match;
    logic [NUM_ENTRIES-1:0] w_free;
    logic [NUM_ENTRIES-1:0] w_free_oh;
    logic                   w_any_free;
    logic                   w_up_found;
    logic [INDEX_WIDTH-1:0] w_up_match_idx;
    logic [INDEX_WIDTH-1:0] w_free_idx;
    logic [INDEX_WIDTH-1:0] w_victim_idx;
    logic [INDEX_WIDTH-1:0] w_ins_idx;
    logic                   w_do_update;
    logic                   w_insert;
    logic                   w_invalidate;
    logic                   w_evict;
    logic [KEY_WIDTH-1:0]   w_evict_key;
    logic [INDEX_WIDTH-1:0] w_upd_idx;
    logic                   w_lk_hit;
    logic [INDEX_WIDTH-1:0] w_lk_idx;

    always_comb begin
        w_lk_match = '0;
        w_up_match = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_lk_match[i] = r_valid[i] && (r_key[i] == lookup_key);
            w_up_match[i] = r_valid[i] && (r_key[i] == update_key);
        end
    end

    // Lowest invalid slot: isolate the least-significant set bit.
    assign w_free         = ~r_valid;
    assign w_free_oh      = w_free & (~w_free + NUM_ENTRIES'(1));
    assign w_any_free     = |w_free;
    assign w_free_idx     = INDEX_WIDTH'(oh_to_idx(c_max_entries'(w_free_oh)));
    assign w_up_found     = |w_up_match;
    assign w_up_match_idx = INDEX_WIDTH'(oh_to_idx(c_max_entries'(w_up_match)));

    assign w_do_update  = update_en && !flush_en;
    assign w_insert     = w_do_update && update_valid;
    assign w_invalidate = w_do_update && !update_valid;

    assign w_ins_idx   = w_up_found ? w_up_match_idx :
                         w_any_free ? w_free_idx : w_victim_idx;
    assign w_evict     = w_insert && !w_up_found && !w_any_free;
    assign w_evict_key = w_evict ? r_key[w_victim_idx] : '0;
    assign w_upd_idx   = w_insert                    ? w_ins_idx :
                         (w_invalidate && w_up_found) ? w_up_match_idx : '0;

    always_comb begin
        w_lk_hit = lookup_en && (|w_lk_match);
        w_lk_idx = w_lk_hit ? INDEX_WIDTH'(oh_to_idx(c_max_entries'(w_lk_match))) : '0;
`ifdef LRU_CAM_BYPASS_EN
        if (lookup_en && w_do_update && (lookup_key == update_key)) begin
            w_lk_hit = update_valid;
            w_lk_idx = update_valid ? w_ins_idx : '0;
        end
`endif
    end

    lru_age_tracker #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_age (
        .clk         (clk),
        .reset       (reset),
        .flush_en    (flush_en),
        .touch_a_en  (w_lk_hit),
        .touch_a_idx (w_lk_idx),
        .touch_b_en  (w_insert),
        .touch_b_idx (w_ins_idx),
        .victim_idx  (w_victim_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid          <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) r_key[i] <= '0;
            lookup_hit       <= 1'b0;
            lookup_idx       <= '0;
            update_idx       <= '0;
            update_found     <= 1'b0;
            update_evict     <= 1'b0;
            update_evict_key <= '0;
        end else begin
            lookup_hit       <= w_lk_hit;
            lookup_idx       <= w_lk_idx;
            update_idx       <= w_upd_idx;
            update_found     <= w_do_update && w_up_found;
            update_evict     <= w_evict;
            update_evict_key <= w_evict_key;
            if (flush_en) begin
                r_valid <= '0;
            end else if (w_insert) begin
                r_valid[w_ins_idx] <= 1'b1;
                r_key[w_ins_idx]   <= update_key;
            end else if (w_invalidate && w_up_found) begin
                r_valid[w_up_match_idx] <= 1'b0;
            end
        end
    end

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                for (int j = i + 1; j < NUM_ENTRIES; j++) begin
                    if (r_valid[i] && r_valid[j] && (r_key[i] == r_key[j]))
                        $error("lru_cam: duplicate valid key in slots %0d and %0d", i, j);
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire
